// File: rtl/sys_array_pkg.sv
// Shared types and constants for the systolic-array result drain.
package sys_array_pkg;

  localparam int unsigned IDX_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    STREAM  = 2'd3
  } drain_state_e;

  typedef struct packed {
    logic [IDX_WIDTH-1:0] o_w0;
    logic [IDX_WIDTH-1:0] o_l0;
    logic [IDX_WIDTH-1:0] rows;
    logic [IDX_WIDTH-1:0] cols;
    logic                 last;
  } drain_tile_desc_t;

endpackage

// File: rtl/sys_array_out_stream.sv
// Row-major index walker for the result stream with valid/ready hold and last-beat flag.
module sys_array_out_stream
  import sys_array_pkg::*;
#(
  parameter int unsigned ROWS = 2,
  parameter int unsigned COLS = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 ready,
  output logic                 valid,
  output logic [IDX_WIDTH-1:0] row,
  output logic [IDX_WIDTH-1:0] col,
  output logic                 last,
  output logic                 xfer_c,
  output logic                 done_c,
  output logic                 nxt_valid_c,
  output logic [IDX_WIDTH-1:0] nxt_row_c,
  output logic [IDX_WIDTH-1:0] nxt_col_c
);

  logic                 valid_q, valid_d;
  logic [IDX_WIDTH-1:0] row_q, row_d;
  logic [IDX_WIDTH-1:0] col_q, col_d;
  logic                 last_q, last_d;

  // Advance the index on each accepted beat; hold everything while ready is low.
  always_comb begin
    valid_d = valid_q;
    row_d   = row_q;
    col_d   = col_q;
    xfer_c  = valid_q && ready;
    done_c  = xfer_c && last_q;
    if (start) begin
      valid_d = 1'b1;
      row_d   = '0;
      col_d   = '0;
    end else if (xfer_c) begin
      if (last_q) begin
        valid_d = 1'b0;
        row_d   = '0;
        col_d   = '0;
      end else if (col_q == IDX_WIDTH'(COLS - 1)) begin
        col_d = '0;
        row_d = row_q + IDX_WIDTH'(1);
      end else begin
        col_d = col_q + IDX_WIDTH'(1);
      end
    end
    last_d      = valid_d && (row_d == IDX_WIDTH'(ROWS - 1)) && (col_d == IDX_WIDTH'(COLS - 1));
    nxt_valid_c = valid_d;
    nxt_row_c   = row_d;
    nxt_col_c   = col_d;
  end

  // Stream index registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      row_q   <= row_d;
      col_q   <= col_d;
      last_q  <= last_d;
    end
  end

  assign valid = valid_q;
  assign row   = row_q;
  assign col   = col_q;
  assign last  = last_q;

endmodule

// File: rtl/sys_array_drain.sv
// De-skews systolic partial sums into an accumulating output buffer and streams the finished matrix.
module sys_array_drain
  import sys_array_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ARRAY_MAX_W   = 10,
  parameter int unsigned ARRAY_MAX_A_L = 10,
  parameter int unsigned OUT_W         = 2,
  parameter int unsigned OUT_L         = 2
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic                                    tile_start,
  input  logic [15:0]                             tile_o_w0,
  input  logic [15:0]                             tile_o_l0,
  input  logic [15:0]                             tile_rows,
  input  logic [15:0]                             tile_cols,
  input  logic                                    tile_last,
  input  logic                                    psum_valid,
  input  logic [0:ARRAY_MAX_W-1][2*DATA_WIDTH-1:0] psum_data,
  output logic                                    busy,
  output logic                                    tile_done,
  output logic                                    tile_err,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [2*DATA_WIDTH-1:0]                 out_data,
  output logic [15:0]                             out_row,
  output logic [15:0]                             out_col,
  output logic                                    out_last
);

  localparam int unsigned PSUM_W = 2 * DATA_WIDTH;

  drain_state_e         state_q, state_d;
  drain_tile_desc_t     desc_q, desc_d;
  logic [IDX_WIDTH-1:0] k_q, k_d;
  logic                 tile_done_q, tile_done_d;
  logic                 tile_err_q, tile_err_d;
  logic                 busy_q, busy_d;
  logic [PSUM_W-1:0]    out_data_q, out_data_d;
  logic [PSUM_W-1:0]    acc_q [OUT_W][OUT_L];
  logic [PSUM_W-1:0]    acc_d [OUT_W][OUT_L];

  logic                 desc_ok_c, cap_en_c, cap_last_c, stream_start_c;
  logic [IDX_WIDTH-1:0] k_cur_c, last_k_c;
  logic                 xfer_c, done_c, nxt_valid_c;
  logic [IDX_WIDTH-1:0] nxt_row_c, nxt_col_c;

  // Descriptor legality and capture-cycle bookkeeping.
  always_comb begin
    desc_ok_c = (tile_rows != '0) && (tile_cols != '0) &&
                (32'(tile_rows) <= ARRAY_MAX_W) && (32'(tile_cols) <= ARRAY_MAX_A_L) &&
                (32'(tile_o_w0) + 32'(tile_rows) <= OUT_W) &&
                (32'(tile_o_l0) + 32'(tile_cols) <= OUT_L);
    k_cur_c        = (state_q == ARMED) ? '0 : k_q;
    last_k_c       = desc_q.rows + desc_q.cols - IDX_WIDTH'(2);
    cap_en_c       = ((state_q == ARMED) && psum_valid) || (state_q == CAPTURE);
    cap_last_c     = cap_en_c && (k_cur_c == last_k_c);
    stream_start_c = tile_done_q && (state_q == STREAM);
  end

  // Control FSM next state.
  always_comb begin
    state_d     = state_q;
    desc_d      = desc_q;
    k_d         = k_q;
    tile_done_d = 1'b0;
    tile_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (tile_start) begin
          if (desc_ok_c) begin
            desc_d  = '{o_w0: tile_o_w0, o_l0: tile_o_l0, rows: tile_rows,
                        cols: tile_cols, last: tile_last};
            state_d = ARMED;
          end else begin
            tile_err_d = 1'b1;
          end
        end
      end
      ARMED, CAPTURE: begin
        if (cap_en_c) begin
          if (cap_last_c) begin
            tile_done_d = 1'b1;
            state_d     = desc_q.last ? STREAM : IDLE;
          end else begin
            state_d = CAPTURE;
            k_d     = k_cur_c + IDX_WIDTH'(1);
          end
        end
      end
      STREAM: begin
        if (done_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Accumulator update: de-skewed add during capture, clear-on-transfer while streaming.
  always_comb begin
    acc_d = acc_q;
    for (int unsigned i = 0; i < OUT_W; i++) begin
      for (int unsigned j = 0; j < OUT_L; j++) begin
        if (cap_en_c) begin
          for (int unsigned r = 0; r < ARRAY_MAX_W; r++) begin
            if ((r < 32'(desc_q.rows)) && (i == 32'(desc_q.o_w0) + r) &&
                (j >= 32'(desc_q.o_l0)) && (j - 32'(desc_q.o_l0) < 32'(desc_q.cols)) &&
                (r + j - 32'(desc_q.o_l0) == 32'(k_cur_c))) begin
              acc_d[i][j] = acc_q[i][j] + psum_data[r];
            end
          end
        end
        if (xfer_c && (out_row == IDX_WIDTH'(i)) && (out_col == IDX_WIDTH'(j))) begin
          acc_d[i][j] = '0;
        end
      end
    end
  end

  // Output data register follows the element the stream will present next.
  always_comb begin
    out_data_d = '0;
    for (int unsigned i = 0; i < OUT_W; i++) begin
      for (int unsigned j = 0; j < OUT_L; j++) begin
        if (nxt_valid_c && (nxt_row_c == IDX_WIDTH'(i)) && (nxt_col_c == IDX_WIDTH'(j))) begin
          out_data_d = acc_q[i][j];
        end
      end
    end
  end

  // State, descriptor, accumulator and pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      desc_q      <= '0;
      k_q         <= '0;
      tile_done_q <= 1'b0;
      tile_err_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_data_q  <= '0;
      for (int unsigned i = 0; i < OUT_W; i++) begin
        for (int unsigned j = 0; j < OUT_L; j++) begin
          acc_q[i][j] <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      desc_q      <= desc_d;
      k_q         <= k_d;
      tile_done_q <= tile_done_d;
      tile_err_q  <= tile_err_d;
      busy_q      <= busy_d;
      out_data_q  <= out_data_d;
      acc_q       <= acc_d;
    end
  end

  sys_array_out_stream #(
    .ROWS(OUT_W),
    .COLS(OUT_L)
  ) u_out_stream (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (stream_start_c),
    .ready      (out_ready),
    .valid      (out_valid),
    .row        (out_row),
    .col        (out_col),
    .last       (out_last),
    .xfer_c     (xfer_c),
    .done_c     (done_c),
    .nxt_valid_c(nxt_valid_c),
    .nxt_row_c  (nxt_row_c),
    .nxt_col_c  (nxt_col_c)
  );

  assign busy      = busy_q;
  assign tile_done = tile_done_q;
  assign tile_err  = tile_err_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_sys_array_drain.sv
// Directed bench for sys_array_drain on a 2x2 array draining into a 2x2 result matrix.
module tb_sys_array_drain;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 2;
  localparam int unsigned AL = 2;
  localparam int unsigned OW = 2;
  localparam int unsigned OL = 2;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic                      tile_start;
  logic [15:0]               tile_o_w0, tile_o_l0, tile_rows, tile_cols;
  logic                      tile_last;
  logic                      psum_valid;
  logic [0:AW-1][2*DW-1:0]   psum_data;
  logic                      busy, tile_done, tile_err;
  logic                      out_valid, out_ready, out_last;
  logic [2*DW-1:0]           out_data;
  logic [15:0]               out_row, out_col;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sys_array_drain #(
    .DATA_WIDTH(DW), .ARRAY_MAX_W(AW), .ARRAY_MAX_A_L(AL), .OUT_W(OW), .OUT_L(OL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .tile_start(tile_start),
    .tile_o_w0(tile_o_w0), .tile_o_l0(tile_o_l0), .tile_rows(tile_rows),
    .tile_cols(tile_cols), .tile_last(tile_last), .psum_valid(psum_valid),
    .psum_data(psum_data), .busy(busy), .tile_done(tile_done), .tile_err(tile_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_tile(input logic [15:0] w0, input logic [15:0] l0,
                           input logic [15:0] rows, input logic [15:0] cols, input logic last);
    tile_start = 1'b1; tile_o_w0 = w0; tile_o_l0 = l0;
    tile_rows = rows; tile_cols = cols; tile_last = last;
    step();
    tile_start = 1'b0;
  endtask

  // Skewed 2x2 feed; junk is placed on lanes that the skew must ignore.
  task automatic skew2x2(input logic [15:0] d00, input logic [15:0] d01,
                         input logic [15:0] d10, input logic [15:0] d11);
    psum_valid = 1'b1; psum_data[0] = d00; psum_data[1] = 16'hDEAD;
    step();
    psum_valid = 1'b0; psum_data[0] = d01; psum_data[1] = d10;
    step();
    psum_data[0] = 16'hBEEF; psum_data[1] = d11;
    step();
    psum_data[0] = '0; psum_data[1] = '0;
  endtask

  task automatic drain_and_check(input string name, input logic [15:0] e0, input logic [15:0] e1,
                                 input logic [15:0] e2, input logic [15:0] e3);
    logic [15:0] exp_d [4];
    exp_d = '{e0, e1, e2, e3};
    out_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_d[b] || out_row !== 16'(b / 2) ||
          out_col !== 16'(b % 2) || out_last !== (b == 3)) begin
        errors++;
        $display("FAIL %s beat%0d: got v=%0b d=%h r=%0d c=%0d l=%0b, want v=1 d=%h r=%0d c=%0d l=%0b",
                 name, b, out_valid, out_data, out_row, out_col, out_last,
                 exp_d[b], b / 2, b % 2, (b == 3));
      end
      step();
    end
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s end: got v=%0b busy=%0b, want v=0 busy=0", name, out_valid, busy);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; tile_start = 1'b0; tile_o_w0 = '0; tile_o_l0 = '0;
    tile_rows = '0; tile_cols = '0; tile_last = 1'b0; psum_valid = 1'b0;
    psum_data = '0; out_ready = 1'b0;
    step(); step();
    checks++;
    if (busy !== 1'b0 || tile_done !== 1'b0 || tile_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got busy=%0b done=%0b err=%0b, want 0 0 0", busy, tile_done, tile_err);
    end
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_row !== '0 || out_col !== '0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: got v=%0b d=%h r=%0d c=%0d l=%0b, want all 0",
               out_valid, out_data, out_row, out_col, out_last);
    end
    @(negedge clk);
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_single_tile();
    send_tile(16'd0, 16'd0, 16'd2, 16'd2, 1'b1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL single_armed: got busy=%0b, want 1", busy);
    end
    skew2x2(16'd5, 16'd6, 16'd7, 16'd8);
    checks++;
    if (tile_done !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_done: got done=%0b v=%0b, want done=1 v=0", tile_done, out_valid);
    end
    step();
    drain_and_check("single", 16'd5, 16'd6, 16'd7, 16'd8);
  endtask

  task automatic test_ksplit();
    send_tile(16'd0, 16'd0, 16'd2, 16'd2, 1'b0);
    skew2x2(16'd5, 16'd6, 16'd7, 16'd8);
    checks++;
    if (tile_done !== 1'b1) begin
      errors++;
      $display("FAIL ksplit_done1: got done=%0b, want 1", tile_done);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ksplit_nostream: got v=%0b busy=%0b, want 0 0", out_valid, busy);
    end
    send_tile(16'd0, 16'd0, 16'd2, 16'd2, 1'b1);
    skew2x2(16'd5, 16'd6, 16'd7, 16'd8);
    step();
    drain_and_check("ksplit", 16'd10, 16'd12, 16'd14, 16'd16);
    send_tile(16'd0, 16'd0, 16'd2, 16'd2, 1'b1);
    skew2x2(16'd5, 16'd6, 16'd7, 16'd8);
    step();
    drain_and_check("ksplit_cleared", 16'd5, 16'd6, 16'd7, 16'd8);
  endtask

  task automatic test_offset();
    send_tile(16'd1, 16'd1, 16'd1, 16'd1, 1'b1);
    psum_valid = 1'b1; psum_data[0] = 16'd9; psum_data[1] = 16'hFFFF;
    step();
    psum_valid = 1'b0; psum_data = '0;
    checks++;
    if (tile_done !== 1'b1) begin
      errors++;
      $display("FAIL offset_done: got done=%0b, want 1", tile_done);
    end
    step();
    drain_and_check("offset", 16'd0, 16'd0, 16'd0, 16'd9);
  endtask

  task automatic test_backpressure();
    int n;
    out_ready = 1'b0;
    send_tile(16'd0, 16'd0, 16'd2, 16'd2, 1'b1);
    skew2x2(16'd1, 16'd2, 16'd3, 16'd4);
    step();
    for (int h = 0; h < 3; h++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'd1 || out_row !== 16'd0 || out_col !== 16'd0) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%0b d=%h r=%0d c=%0d, want v=1 d=0001 r=0 c=0",
                 h, out_valid, out_data, out_row, out_col);
      end
      step();
    end
    n = 0;
    for (int cyc = 0; cyc < 20 && out_valid === 1'b1; cyc++) begin
      out_ready = (cyc % 2 == 0);
      if (out_ready) begin
        checks++;
        if (n >= 4 || out_row !== 16'(n / 2) || out_col !== 16'(n % 2) || out_data !== 16'(n + 1)) begin
          errors++;
          $display("FAIL bp_beat%0d: got d=%h r=%0d c=%0d, want d=%0d r=%0d c=%0d",
                   n, out_data, out_row, out_col, n + 1, n / 2, n % 2);
        end
        n++;
      end
      step();
    end
    checks++;
    if (n != 4 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_count: got transfers=%0d v=%0b, want 4 v=0", n, out_valid);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reject_busy();
    send_tile(16'd1, 16'd0, 16'd2, 16'd1, 1'b1);
    checks++;
    if (tile_err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reject_pulse: got err=%0b busy=%0b, want 1 0", tile_err, busy);
    end
    step();
    checks++;
    if (tile_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reject_after: got err=%0b busy=%0b, want 0 0", tile_err, busy);
    end
    send_tile(16'd0, 16'd0, 16'd0, 16'd1, 1'b1);
    checks++;
    if (tile_err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reject_zero: got err=%0b busy=%0b, want 1 0", tile_err, busy);
    end
    step();
    send_tile(16'd0, 16'd0, 16'd2, 16'd2, 1'b1);
    psum_valid = 1'b1; psum_data[0] = 16'd1; psum_data[1] = 16'hDEAD;
    step();
    tile_start = 1'b1; tile_o_w0 = 16'd1; tile_o_l0 = 16'd1;
    tile_rows = 16'd2; tile_cols = 16'd2; tile_last = 1'b0;
    psum_valid = 1'b0; psum_data[0] = 16'd2; psum_data[1] = 16'd3;
    step();
    tile_start = 1'b0;
    checks++;
    if (tile_err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_ignore: got err=%0b busy=%0b, want 0 1", tile_err, busy);
    end
    psum_data[0] = 16'hBEEF; psum_data[1] = 16'd4;
    step();
    psum_data = '0;
    step();
    drain_and_check("busy_stream", 16'd1, 16'd2, 16'd3, 16'd4);
  endtask

  task automatic test_reset_wrap();
    send_tile(16'd0, 16'd0, 16'd2, 16'd2, 1'b1);
    skew2x2(16'd1, 16'd2, 16'd3, 16'd4);
    step();
    out_ready = 1'b1;
    step(); step();
    checks++;
    if (out_valid !== 1'b1 || out_row !== 16'd1 || out_col !== 16'd0) begin
      errors++;
      $display("FAIL rst_beat2: got v=%0b r=%0d c=%0d, want v=1 r=1 c=0", out_valid, out_row, out_col);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL rst_drop: got v=%0b busy=%0b d=%h, want 0 0 0000", out_valid, busy, out_data);
    end
    @(negedge clk);
    reset_n = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_nobeat: got v=%0b, want 0", out_valid);
    end
    send_tile(16'd0, 16'd0, 16'd1, 16'd1, 1'b1);
    psum_valid = 1'b1; psum_data[0] = 16'd0;
    step();
    psum_valid = 1'b0;
    step();
    drain_and_check("rst_cleared", 16'd0, 16'd0, 16'd0, 16'd0);
    send_tile(16'd0, 16'd0, 16'd1, 16'd1, 1'b0);
    psum_valid = 1'b1; psum_data[0] = 16'hFFFF;
    step();
    psum_valid = 1'b0;
    step();
    send_tile(16'd0, 16'd0, 16'd1, 16'd1, 1'b1);
    psum_valid = 1'b1; psum_data[0] = 16'h0002;
    step();
    psum_valid = 1'b0; psum_data = '0;
    step();
    drain_and_check("wrap", 16'h0001, 16'd0, 16'd0, 16'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_tile();
    test_ksplit();
    test_offset();
    test_backpressure();
    test_reject_busy();
    test_reset_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sys_array_drain.md
Name: sys_array_drain

Overview:
- Result-side counterpart of the tile fetcher: collects the skewed partial sums that the systolic array emits per output row and de-skews them by row and column.
- Accumulates each tile into a full-size output buffer at the tile's row/column offset.
- After the last tile of a job, streams the finished matrix out row-major over a valid/ready handshake.
- Sits between sys_array_basic's output rows and the downstream result consumer.

Parameters:
DATA_WIDTH, 8, operand width; partial sums and results are 2*DATA_WIDTH bits.
ARRAY_MAX_W, 10, number of systolic array output rows.
ARRAY_MAX_A_L, 10, maximum number of columns per tile.
OUT_W, 2, rows of the full output matrix.
OUT_L, 2, columns of the full output matrix.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
tile_start  in  1  one-cycle pulse; latches the tile descriptor
tile_o_w0  in  16  output row offset of the tile
tile_o_l0  in  16  output column offset of the tile
tile_rows  in  16  valid rows in the tile, 1..ARRAY_MAX_W
tile_cols  in  16  valid columns in the tile, 1..ARRAY_MAX_A_L
tile_last  in  1  tile is the last of the job
psum_valid  in  1  marks cycle t0, when row 0 / column 0 is on the bus
psum_data  in  ARRAY_MAX_W*2*DATA_WIDTH  one partial sum per array row, packed [0:ARRAY_MAX_W-1]
busy  out  1  high in every state except IDLE
tile_done  out  1  one-cycle pulse when a tile's capture completes
tile_err  out  1  one-cycle pulse when a descriptor is rejected
out_valid  out  1  result beat valid
out_ready  in  1  consumer accepts beat
out_data  out  2*DATA_WIDTH  result element
out_row  out  16  row index of the beat
out_col  out  16  column index of the beat
out_last  out  1  final beat of the matrix

Behaviour:
- Reset (asynchronous, reset_n low):
  - state = IDLE; all outputs 0.
  - Accumulator buffer OUT_W x OUT_L cleared to 0.
  - Asserting reset mid-capture or mid-stream abandons the job; no partial beats follow.
- States: IDLE, ARMED, CAPTURE, STREAM.
- IDLE:
  - On tile_start, check the descriptor. It is rejected if tile_rows==0, tile_cols==0, tile_rows>ARRAY_MAX_W, tile_cols>ARRAY_MAX_A_L, tile_o_w0+tile_rows>OUT_W, or tile_o_l0+tile_cols>OUT_L.
  - Rejected descriptor: tile_err pulses the next cycle and the block stays in IDLE.
  - Accepted descriptor: it is latched, including tile_last, and the block moves to ARMED.
- ARMED:
  - Waits for psum_valid. The cycle psum_valid is high is t0 and is processed as capture cycle k=0; the block enters CAPTURE the next cycle.
  - psum_valid is ignored in every state other than ARMED.
- Capture rule:
  - At capture cycle k = t - t0, for every row r < tile_rows with c = k - r and 0 <= c < tile_cols, perform acc[o_w0+r][o_l0+c] += psum_data[r].
  - The add is modulo 2^(2*DATA_WIDTH): wrap, no saturation.
  - Rows r >= tile_rows are ignored.
- Capture length is tile_rows+tile_cols-1 cycles (k = 0..rows+cols-2).
- On the final capture cycle:
  - tile_done pulses the following cycle.
  - If tile_last, the next state is STREAM; otherwise the next state is IDLE and the accumulator is kept for the next tile.
- STREAM:
  - out_valid rises the cycle after tile_done and stays high until the last beat is accepted.
  - Beats go row-major from (0,0) to (OUT_W-1,OUT_L-1). out_last is high only on beat (OUT_W-1,OUT_L-1).
  - A beat transfers when out_valid && out_ready. While out_ready is low, out_data/out_row/out_col/out_last hold stable.
  - Each element's accumulator is zeroed as it transfers.
  - After the last transfer: IDLE, out_valid=0.
- tile_start while busy is ignored: no error, descriptor not latched. This includes the cycle of the last STREAM transfer.
- Accumulation across tiles at the same offset is the required behaviour (K-dimension split). Overlapping tiles simply add.

Decomposition:
- Shared package sys_array_pkg holds:
  - the drain state enum (IDLE, ARMED, CAPTURE, STREAM);
  - a packed drain_tile_desc struct {o_w0, o_l0, rows, cols: 16 bits each; last: 1 bit};
  - the constant IDX_WIDTH = 16.
- One natural sub-module, sys_array_out_stream: a row-major index counter with valid/ready hold logic and out_last generation.
- The capture/accumulate datapath stays in sys_array_drain.

Test Plan:
- Skewed single tile, OUT=2x2, ARRAY_MAX_W=2, ARRAY_MAX_A_L=2:
  - Stimulus: tile (0,0,2,2,last=1); t0 row0=5; t0+1 row0=6, row1=7; t0+2 row1=8.
  - Response: tile_done one cycle after t0+2; beats 5,6,7,8 at (0,0),(0,1),(1,0),(1,1); out_last only on the 4th beat.
- K-split accumulation:
  - Stimulus: the same tile sent twice, last=0 then last=1, same data.
  - Response: only one stream, carrying 10,12,14,16. A following job using the same data streams 5,6,7,8, which proves the buffer was cleared.
- Offset and row masking:
  - Stimulus: tile (1,1,1,1,last=1), t0 row0=9, row1=0xFFFF.
  - Response: stream 0,0,0,9; row1 has no effect.
- Backpressure:
  - Stimulus: out_ready low for 3 cycles after out_valid rises, then toggled 1/0.
  - Response: beat 0 held stable 3 cycles; exactly 4 transfers; no duplicated or skipped index.
- Rejection and busy:
  - Stimulus: tile (1,0,2,1) → tile_err pulses one cycle, state remains IDLE. tile_start during CAPTURE → ignored, no tile_err.
- Reset and wrap:
  - Stimulus: assert reset_n low during STREAM beat 2.
  - Response: out_valid drops immediately; after release the buffer reads all zero.
  - Wrap check: accumulating 0xFFFF+0x0002 yields 0x0001.
